voting_seq_ctrl: RTL and testbench

//   Sequential controller for the plurality vote datapath: accepts one ballot per cycle over a

---
 rtl/voting_seq_ctrl_if.sv | 35 +++
 rtl/voting_seq_ctrl.sv | 114 +++++++++++
 tb/tb_voting_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/voting_seq_ctrl_if.sv
// Ballot/result bus for the sequential plurality vote controller.
//   master: election driver (start, ballots in; status and result back)
//   slave : the controller itself
// Signals:
//   start        begin a new election (honoured only when idle or done)
//   vote_valid   a ballot is present on vote
//   vote         candidate index being voted for (N bits)
//   vote_ready   controller accepts a ballot this cycle
//   busy         election in progress (collecting or scanning)
//   done         result valid, held until the next start or reset
//   winner       winning candidate index (N bits)
//   winner_count tally of the winning candidate (M+1 bits)
interface voting_seq_ctrl_if #(
  parameter int N = 2,
  parameter int M = 2
);
  logic         start;
  logic         vote_valid;
  logic [N-1:0] vote;
  logic         vote_ready;
  logic         busy;
  logic         done;
  logic [N-1:0] winner;
  logic [M:0]   winner_count;

  modport master (
    output start, vote_valid, vote,
    input  vote_ready, busy, done, winner, winner_count
  );

  modport slave (
    input  start, vote_valid, vote,
    output vote_ready, busy, done, winner, winner_count
  );
endinterface

// File: rtl/voting_seq_ctrl.sv
// Sequential plurality vote controller.
// Collects 2**M ballots over a valid/ready handshake into per-candidate
// tallies, then scans the 2**N tallies one per cycle and reports the
// candidate with the highest tally (ties go to the lowest index).
// Ports:
//   clk  rising-edge clock for all state
//   rst  synchronous active-high reset, returns to idle with everything cleared
//   bus  voting_seq_ctrl_if slave modport (start, ballot handshake, status, result)
module voting_seq_ctrl #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic              clk,
  input  logic              rst,
  voting_seq_ctrl_if.slave  bus
);
  localparam int NC = 2 ** N;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_SCAN    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Count value when the final ballot of an election is being accepted.
  localparam logic [M:0] LAST_BALLOT = (M+1)'(2 ** M - 1);

  logic [1:0]   state;
  logic [M:0]   tally [NC];
  logic [M:0]   ballot_cnt;
  logic [N-1:0] scan_idx;
  logic [N-1:0] best_idx;
  logic [M:0]   best_cnt;
  logic [N-1:0] winner_q;
  logic [M:0]   winner_count_q;

  logic         take;
  logic [N-1:0] next_best_idx;
  logic [M:0]   next_best_cnt;

  // Index 0 seeds the best register unconditionally; later candidates only
  // displace it when strictly greater, which keeps ties on the lowest index.
  always_comb begin
    take          = (scan_idx == '0) || (tally[scan_idx] > best_cnt);
    next_best_idx = best_idx;
    next_best_cnt = best_cnt;
    if (take) begin
      next_best_idx = scan_idx;
      next_best_cnt = tally[scan_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ballot_cnt     <= '0;
      scan_idx       <= '0;
      best_idx       <= '0;
      best_cnt       <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
      for (int k = 0; k < NC; k++) tally[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < NC; k++) tally[k] <= '0;
            ballot_cnt <= '0;
            state      <= S_COLLECT;
          end
        end
        // vote_ready is high throughout this state, so vote_valid alone
        // completes the handshake.
        S_COLLECT: begin
          if (bus.vote_valid) begin
            tally[bus.vote] <= tally[bus.vote] + 1'b1;
            ballot_cnt      <= ballot_cnt + 1'b1;
            if (ballot_cnt == LAST_BALLOT) begin
              scan_idx <= '0;
              state    <= S_SCAN;
            end
          end
        end
        // The result registers are loaded from the combinational next-best
        // value so the last candidate is included without an extra cycle.
        S_SCAN: begin
          best_idx <= next_best_idx;
          best_cnt <= next_best_cnt;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == '1) begin
            winner_q       <= next_best_idx;
            winner_count_q <= next_best_cnt;
            state          <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            for (int k = 0; k < NC; k++) tally[k] <= '0;
            ballot_cnt     <= '0;
            winner_q       <= '0;
            winner_count_q <= '0;
            state          <= S_COLLECT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.vote_ready   = (state == S_COLLECT);
  assign bus.busy         = (state == S_COLLECT) || (state == S_SCAN);
  assign bus.done         = (state == S_DONE);
  assign bus.winner       = winner_q;
  assign bus.winner_count = winner_count_q;
endmodule

// File: tb/tb_voting_seq_ctrl.sv
// Self-checking bench for voting_seq_ctrl (N=2, M=2): directed elections plus
// randomized ones, each compared against a counting model of a plurality vote.
module tb_voting_seq_ctrl;
  localparam int N  = 2;
  localparam int M  = 2;
  localparam int NC = 2 ** N;
  localparam int NB = 2 ** M;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voting_seq_ctrl_if #(.N(N), .M(M)) bus ();

  voting_seq_ctrl #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plurality winner: count ballots per candidate, highest count wins,
  // first (lowest) candidate kept on a tie.
  function automatic void model(input int votes[$], output int w, output int c);
    int counts [NC];
    foreach (counts[k]) counts[k] = 0;
    foreach (votes[k]) counts[votes[k]]++;
    w = 0;
    c = counts[0];
    for (int k = 1; k < NC; k++) begin
      if (counts[k] > c) begin
        w = k;
        c = counts[k];
      end
    end
  endfunction

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Drives ballots (optionally with idle gaps) and then waits for done,
  // reporting raw observations for the calling test to judge.
  task automatic drive_election(input int votes[$], input bit gaps, input bit hold_valid,
                                output int missed_ready, output int latency,
                                output int ready_in_scan, output int result_moved);
    missed_ready  = 0;
    ready_in_scan = 0;
    result_moved  = 0;
    foreach (votes[k]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.vote_valid = 1'b0;
          bus.vote       = N'($urandom_range(0, NC - 1));
          if (bus.winner !== '0 || bus.winner_count !== '0) result_moved++;
          tick();
        end
      end
      bus.vote_valid = 1'b1;
      bus.vote       = N'(votes[k]);
      if (bus.vote_ready !== 1'b1) missed_ready++;
      if (bus.winner !== '0 || bus.winner_count !== '0) result_moved++;
      tick();
    end
    bus.vote_valid = hold_valid;
    latency = 0;
    while (bus.done !== 1'b1 && latency < 16) begin
      bus.vote = N'($urandom_range(0, NC - 1));
      if (bus.vote_ready !== 1'b0) ready_in_scan++;
      if (bus.winner !== '0 || bus.winner_count !== '0) result_moved++;
      tick();
      latency++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    vectors++;
    if ({bus.vote_ready, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got ready/busy/done=%b expected 000",
               {bus.vote_ready, bus.busy, bus.done});
    end
    vectors++;
    if (bus.winner !== '0 || bus.winner_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got winner=%0d count=%0d expected 0/0",
               bus.winner, bus.winner_count);
    end
  endtask

  // Runs one election from idle or done and checks everything observable.
  task automatic test_election(input string name, input int votes[$], input bit gaps,
                               input bit hold_valid);
    int ew, ec, missed, lat, rdy, moved;
    model(votes, ew, ec);
    do_start();
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.winner !== '0 || bus.winner_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s_start: got done=%b busy=%b winner=%0d count=%0d expected 0 1 0 0",
               name, bus.done, bus.busy, bus.winner, bus.winner_count);
    end
    drive_election(votes, gaps, hold_valid, missed, lat, rdy, moved);
    vectors++;
    if (missed !== 0) begin
      miscompares++;
      $display("[TB] FAIL %s_ready: got %0d ballots without vote_ready expected 0", name, missed);
    end
    vectors++;
    if (lat !== NC) begin
      miscompares++;
      $display("[TB] FAIL %s_latency: got %0d edges expected %0d", name, lat, NC);
    end
    vectors++;
    if (rdy !== 0 || moved !== 0) begin
      miscompares++;
      $display("[TB] FAIL %s_scan: got ready-in-scan=%0d result-changes=%0d expected 0/0",
               name, rdy, moved);
    end
    vectors++;
    if (bus.winner !== N'(ew) || bus.winner_count !== (M+1)'(ec)) begin
      miscompares++;
      $display("[TB] FAIL %s_result: got winner=%0d count=%0d expected %0d/%0d",
               name, bus.winner, bus.winner_count, ew, ec);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.vote_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_done_status: got busy=%b ready=%b expected 0/0",
               name, bus.busy, bus.vote_ready);
    end
    bus.vote_valid = 1'b0;
  endtask

  task automatic test_directed;
    int q[$];
    q = '{1, 1, 2, 3}; test_election("basic", q, 1'b0, 1'b0);
    q = '{3, 0, 3, 0}; test_election("tie_low", q, 1'b0, 1'b0);
    q = '{2, 2, 2, 2}; test_election("full_tally", q, 1'b0, 1'b0);
  endtask

  // Gapped ballots, vote_valid held high through scan and done.
  task automatic test_gaps_and_hold;
    int q[$];
    int ew, ec, bad;
    q = '{0, 3, 3, 1};
    model(q, ew, ec);
    test_election("gaps", q, 1'b1, 1'b1);
    bad = 0;
    repeat (5) begin
      bus.vote_valid = 1'b1;
      bus.vote       = N'($urandom_range(0, NC - 1));
      tick();
      if (bus.done !== 1'b1 || bus.vote_ready !== 1'b0 ||
          bus.winner !== N'(ew) || bus.winner_count !== (M+1)'(ec)) bad++;
    end
    bus.vote_valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL done_hold: got %0d unstable cycles expected 0", bad);
    end
  endtask

  // Reset mid-collection must discard the partial tallies and ballot count.
  task automatic test_reset_mid_collect;
    int q[$];
    do_start();
    bus.vote_valid = 1'b1;
    bus.vote       = N'(1);
    repeat (2) tick();
    bus.vote_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.vote_ready, bus.busy, bus.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL mid_collect_reset: got ready/busy/done=%b expected 000",
               {bus.vote_ready, bus.busy, bus.done});
    end
    q = '{0, 1, 1, 1};
    test_election("after_reset", q, 1'b0, 1'b0);
  endtask

  // Reset in the middle of the scan returns straight to idle.
  task automatic test_reset_mid_scan;
    do_start();
    bus.vote_valid = 1'b1;
    for (int k = 0; k < NB; k++) begin
      bus.vote = N'(3);
      tick();
    end
    bus.vote_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.winner !== '0 || bus.winner_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_scan_reset: got busy=%b done=%b winner=%0d count=%0d expected 0 0 0 0",
               bus.busy, bus.done, bus.winner, bus.winner_count);
    end
  endtask

  // A start pulse during collection must not restart the election.
  task automatic test_start_in_collect;
    int q[$];
    int ew, ec, missed, lat, rdy, moved;
    q = '{3, 3, 3, 0};
    model(q, ew, ec);
    do_start();
    bus.vote_valid = 1'b1;
    bus.vote       = N'(3);
    tick();
    bus.vote_valid = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    q = '{3, 3, 0};
    drive_election(q, 1'b0, 1'b0, missed, lat, rdy, moved);
    vectors++;
    if (bus.winner !== N'(ew) || bus.winner_count !== (M+1)'(ec) || lat !== NC) begin
      miscompares++;
      $display("[TB] FAIL start_ignored: got winner=%0d count=%0d latency=%0d expected %0d/%0d/%0d",
               bus.winner, bus.winner_count, lat, ew, ec, NC);
    end
  endtask

  task automatic test_random;
    int q[$];
    for (int e = 0; e < 8; e++) begin
      q.delete();
      for (int k = 0; k < NB; k++) q.push_back($urandom_range(0, NC - 1));
      test_election("random", q, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.vote_valid = 1'b0;
    bus.vote       = '0;
    test_reset();
    test_directed();
    test_gaps_and_hold();
    test_reset_mid_collect();
    test_start_in_collect();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
